// File: rtl/rr_onehot_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// rr_arb_pkg
// Shared constants for the round-robin one-hot arbiter:
//   N      - number of request lines (fixed at 8 to match the 8-to-3 encoder)
//   IDX_W  - width of a line index / round-robin pointer, log2(N)
//   IDLE, OFFER - FSM state encodings
//   req_vec_t, idx_t - convenience types for request words and line indices
// ----------------------------------------------------------------------------
package rr_arb_pkg;

    localparam int N     = 8;
    localparam int IDX_W = 3;

    typedef logic [N-1:0]     req_vec_t;
    typedef logic [IDX_W-1:0] idx_t;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] OFFER = 1'b1;

endpackage

// File: rtl/rr_onehot_arbiter_if.sv
// ----------------------------------------------------------------------------
// rr_onehot_arbiter_if
// Request/grant bus between the requesters/consumer and the arbiter.
//   req          - request lines, one per requester
//   grant        - one-hot grant word, zero when grant_valid is low
//   grant_valid  - grant word valid (encoder enable)
//   grant_ready  - consumer accepts the current grant
//   pending      - pending-request register, for debug/status
// Modports:
//   master - the arbiter: drives grant, grant_valid, pending
//   slave  - the requesters/consumer: drives req, grant_ready
// ----------------------------------------------------------------------------
interface rr_onehot_arbiter_if import rr_arb_pkg::*; ();

    req_vec_t req;
    req_vec_t grant;
    logic     grant_valid;
    logic     grant_ready;
    req_vec_t pending;

    modport master (
        input  req,
        input  grant_ready,
        output grant,
        output grant_valid,
        output pending
    );

    modport slave (
        output req,
        output grant_ready,
        input  grant,
        input  grant_valid,
        input  pending
    );

endinterface

// File: rtl/rr_onehot_arbiter_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Purely combinational circular first-set-bit finder.
//   pending - candidate request bits
//   ptr     - highest-priority line; search order ptr, ptr+1, ... mod N
//   onehot  - one-hot of the first set bit found, zero if none
//   idx     - index of that bit, zero if none
//   none    - high when pending is all zeros
// ----------------------------------------------------------------------------
module rr_pick import rr_arb_pkg::*; (
    input  req_vec_t pending,
    input  idx_t     ptr,
    output req_vec_t onehot,
    output idx_t     idx,
    output logic     none
);

    // Walk the lines starting at ptr; the index arithmetic wraps naturally
    // because it is IDX_W bits wide and N is a power of two.
    always_comb begin
        logic found;
        idx_t cand;
        found  = 1'b0;
        cand   = '0;
        onehot = '0;
        idx    = '0;
        for (int i = 0; i < N; i++) begin
            cand = ptr + idx_t'(i);
            if (!found && pending[cand]) begin
                found        = 1'b1;
                idx          = cand;
                onehot       = '0;
                onehot[cand] = 1'b1;
            end
        end
        none = !found;
    end

endmodule

// File: rtl/rr_onehot_arbiter.sv
// ----------------------------------------------------------------------------
// rr_onehot_arbiter
// Round-robin arbiter issuing a strictly one-hot grant word with a
// valid/ready handshake, feeding an 8-to-3 encoder downstream.
//   clk - clock, all state changes on the rising edge
//   rst - synchronous active-high reset
//   bus - rr_onehot_arbiter_if.master (req, grant_ready in;
//         grant, grant_valid, pending out)
// ----------------------------------------------------------------------------
module rr_onehot_arbiter import rr_arb_pkg::*; (
    input  logic                       clk,
    input  logic                       rst,
    rr_onehot_arbiter_if.master        bus
);

    logic [0:0] state;
    idx_t       ptr;
    req_vec_t   pending_q;
    req_vec_t   grant_q;
    idx_t       grant_idx;

    req_vec_t   pick_onehot;
    idx_t       pick_idx;
    logic       pick_none;
    logic       accept;
    req_vec_t   clr_mask;

    rr_pick u_pick (
        .pending (pending_q),
        .ptr     (ptr),
        .onehot  (pick_onehot),
        .idx     (pick_idx),
        .none    (pick_none)
    );

    // An accept only happens while offering; the cleared bit is exactly the
    // granted line, and a same-edge request re-sets it (set wins).
    assign accept   = (state == OFFER) && bus.grant_ready;
    assign clr_mask = accept ? grant_q : '0;

    // Pending register, pointer, FSM and grant register. The grant register
    // is cleared when leaving OFFER so it reads zero throughout IDLE, and is
    // only loaded in IDLE so requests arriving during OFFER cannot disturb it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            pending_q <= '0;
            grant_q   <= '0;
            grant_idx <= '0;
        end else begin
            pending_q <= (pending_q & ~clr_mask) | bus.req;
            case (state)
                IDLE: begin
                    if (!pick_none) begin
                        grant_q   <= pick_onehot;
                        grant_idx <= pick_idx;
                        state     <= OFFER;
                    end
                end
                OFFER: begin
                    if (bus.grant_ready) begin
                        grant_q <= '0;
                        ptr     <= grant_idx + idx_t'(1);
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_valid = (state == OFFER);
    assign bus.pending     = pending_q;

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// ----------------------------------------------------------------------------
// tb_rr_onehot_arbiter
// Directed-vector bench for rr_onehot_arbiter with hand-computed expectations.
// ----------------------------------------------------------------------------
module tb_rr_onehot_arbiter;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   grant_count [8];

    rr_onehot_arbiter_if bus ();

    rr_onehot_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Models the downstream 8-to-3 encoder for a one-hot input.
    function automatic logic [7:0] encode(input logic [7:0] onehot);
        logic [7:0] r;
        r = 8'hFF;
        for (int i = 0; i < 8; i++)
            if (onehot[i]) r = 8'(i);
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [7:0] actual,
                               input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Drive inputs just after an edge, then advance past the next edge.
    task automatic applyStimulus(input logic [7:0] r, input logic rdy);
        bus.req         = r;
        bus.grant_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic checkState(input string tag, input logic [7:0] g,
                              input logic v, input logic [7:0] p);
        checkOutput({tag, ".grant"},   bus.grant, g);
        checkOutput({tag, ".valid"},   {7'd0, bus.grant_valid}, {7'd0, v});
        checkOutput({tag, ".pending"}, bus.pending, p);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] exp_g;
        checks   = 0;
        failures = 0;
        for (int i = 0; i < 8; i++) grant_count[i] = 0;
        rst             = 1'b1;
        bus.req         = '0;
        bus.grant_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkState("reset", 8'h00, 1'b0, 8'h00);
        rst = 1'b0;

        // Single request on line 2
        applyStimulus(8'h04, 1'b0);
        checkState("single.set", 8'h00, 1'b0, 8'h04);
        applyStimulus(8'h00, 1'b0);
        checkState("single.offer", 8'h04, 1'b1, 8'h04);
        checkOutput("single.enc", encode(bus.grant), 8'd2);
        applyStimulus(8'h00, 1'b1);
        checkState("single.accept", 8'h00, 1'b0, 8'h00);

        // Backpressure on line 4 (ptr=3)
        applyStimulus(8'h10, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(8'h00, 1'b0);
            checkState("bp.hold", 8'h10, 1'b1, 8'h10);
        end
        applyStimulus(8'h00, 1'b1);
        checkState("bp.accept", 8'h00, 1'b0, 8'h00);

        // Rotation: accept line 3 so ptr=4, then lines 0 and 3 request
        applyStimulus(8'h08, 1'b0);
        applyStimulus(8'h00, 1'b0);
        checkOutput("rot.g3", bus.grant, 8'h08);
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'h09, 1'b0);
        checkState("rot.pend", 8'h00, 1'b0, 8'h09);
        applyStimulus(8'h00, 1'b0);
        checkState("rot.first", 8'h01, 1'b1, 8'h09);
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'h00, 1'b0);
        checkState("rot.second", 8'h08, 1'b1, 8'h08);
        applyStimulus(8'h00, 1'b1);

        // Set-wins: ptr=4, lines 1 and 2 pending, line 1 wins first
        applyStimulus(8'h06, 1'b0);
        applyStimulus(8'h00, 1'b0);
        checkState("sw.offer", 8'h02, 1'b1, 8'h06);
        applyStimulus(8'h02, 1'b1);
        checkState("sw.accept", 8'h00, 1'b0, 8'h06);
        applyStimulus(8'h00, 1'b0);
        checkOutput("sw.next", bus.grant, 8'h04);
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'h00, 1'b0);
        checkState("sw.regrant", 8'h02, 1'b1, 8'h02);
        applyStimulus(8'h00, 1'b1);
        checkState("sw.done", 8'h00, 1'b0, 8'h00);

        // Reset mid-offer (ptr=2 so line 2 is offered), with concurrent req/accept
        applyStimulus(8'h0F, 1'b0);
        applyStimulus(8'h00, 1'b0);
        checkState("rst.offer", 8'h04, 1'b1, 8'h0F);
        rst = 1'b1;
        applyStimulus(8'h0F, 1'b1);
        checkState("rst.clear", 8'h00, 1'b0, 8'h00);
        rst = 1'b0;
        applyStimulus(8'h00, 1'b0);
        applyStimulus(8'h00, 1'b0);
        checkState("rst.quiet", 8'h00, 1'b0, 8'h00);

        // Full contention from ptr=0: grants 01,02,...,80,01,...
        applyStimulus(8'hFF, 1'b1);
        checkState("full.pend", 8'h00, 1'b0, 8'hFF);
        for (int k = 0; k < 16; k++) begin
            exp_g = 8'h01 << (k % 8);
            applyStimulus(8'hFF, 1'b1);
            checkOutput("full.grant", bus.grant, exp_g);
            for (int i = 0; i < 8; i++)
                if (bus.grant[i]) grant_count[i]++;
            applyStimulus(8'hFF, 1'b1);
            checkOutput("full.idle", {7'd0, bus.grant_valid}, 8'h00);
        end
        for (int i = 0; i < 8; i++)
            checkOutput("full.fair", 8'(grant_count[i]), 8'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
